// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_paso.sv
// One restoring step: shift {rem,quo} left, trial-subtract divisor, set quotient bit.
// Purely combinational, no handshake.
module div_paso #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);
  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;

  assign w_sh  = {i_rem, i_quo[WIDTH-1]};
  assign w_ge  = (w_sh >= {1'b0, i_dvs});
  // When w_ge holds, the true difference is below the divisor, so the low bits are exact.
  assign w_sub = w_sh[WIDTH-1:0] - i_dvs;
  assign o_rem = w_ge ? w_sub : w_sh[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};
endmodule

// File: rtl/unidad_division.sv
// Radix-2 restoring divider: 34 cycles start-to-valid (2 for a zero divisor), one-cycle div_valid.
// No backpressure: starts arriving in CALC/FIX are dropped, flush aborts anything in flight.
module unidad_division
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter int RWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [RWIDTH-1:0] rd,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [WIDTH-1:0]  divisor,
  input  logic              flush,
  output logic              busy,
  output logic              div_valid,
  output logic [RWIDTH-1:0] div_Rd,
  output logic [WIDTH-1:0]  div_DI,
  output logic [WIDTH-1:0]  div_rem
);
  localparam int CW = $clog2(DIV_ITER);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITER - 1);

  div_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_rem, r_quo, r_dvs;
  logic              r_neg_q, r_neg_r;
  logic [RWIDTH-1:0] r_rd;

  logic              w_dvd_neg, w_dvs_neg, w_dvs_zero;
  logic [WIDTH-1:0]  w_dvd_mag, w_dvs_mag, w_rem_nxt, w_quo_nxt;

  assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
  assign w_dvs_zero = (divisor == '0);

  div_paso #(.WIDTH(WIDTH)) u_paso (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rd      <= '0;
      busy      <= 1'b0;
      div_valid <= 1'b0;
      div_Rd    <= '0;
      div_DI    <= '0;
      div_rem   <= '0;
    end else begin
      div_valid <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_rd  <= rd;
              r_cnt <= '0;
              r_dvs <= w_dvs_mag;
              busy  <= 1'b1;
              if (w_dvs_zero) begin
                // Preset result bypasses both the iterations and the sign fixup.
                r_quo   <= '1;
                r_rem   <= dividend;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
                r_state <= FIX;
              end else begin
                r_quo   <= w_dvd_mag;
                r_rem   <= '0;
                r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                r_neg_r <= w_dvd_neg;
                r_state <= CALC;
              end
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
          CALC: begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= FIX;
          end
          FIX: begin
            div_DI    <= r_neg_q ? -r_quo : r_quo;
            div_rem   <= r_neg_r ? -r_rem : r_rem;
            div_Rd    <= r_rd;
            div_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= DONE;
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/unidad_division.md
# unidad_division

Iterative 32-bit integer divider in the execution stage, alongside the ALU, load and multiply paths. It accepts one divide per start pulse and runs a radix-2 restoring algorithm for 32 iterations. It returns the quotient, remainder and destination register, tagged with a one-cycle valid. `div_Rd`/`div_DI` feed the forwarding unit's divide inputs and the writeback path.

## Interface
- `WIDTH`, default 32: operand and result width.
- `RWIDTH`, default 4: register-address width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a divide; sampled each rising edge.
- `is_signed`  in  1  1 = two's-complement divide, 0 = unsigned.
- `rd`  in  RWIDTH  destination register of the request.
- `dividend`  in  WIDTH  numerator.
- `divisor`  in  WIDTH  denominator.
- `flush`  in  1  pipeline flush; aborts any operation in flight.
- `busy`  out  1  operation in progress; new starts are ignored.
- `div_valid`  out  1  result valid, exactly one cycle per completed divide.
- `div_Rd`  out  RWIDTH  destination register of the result.
- `div_DI`  out  WIDTH  quotient.
- `div_rem`  out  WIDTH  remainder.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **Accepting a start**
  - A start is accepted only in IDLE or DONE; in CALC or FIX it is ignored, with no queuing.
  - On accept, latch `rd` and `is_signed`, plus the sign of dividend and of divisor.
  - Load the magnitudes |dividend| and |divisor|. Unsigned operands pass through unchanged.
  - Clear the partial remainder and the iteration counter.
  - Go to CALC.
- **Divisor of zero:** go straight to FIX with a preset result.
  - Quotient 0xFFFFFFFF, remainder = raw dividend, in both modes.
- **CALC:** one iteration per cycle.
  - Shift {remainder, quotient} left 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quotient bit 0.
  - After iteration 31 (counter wraps 31->0), go to FIX.
- **FIX:** apply sign fixup.
  - Quotient is negated when the two operand signs differ.
  - Remainder takes the dividend's sign (truncating division).
  - Register `div_DI`, `div_rem` and `div_Rd`, then go to DONE.
- **Signed overflow:** −2^31 / −1 yields quotient 0x80000000, remainder 0 (the natural WIDTH truncation); no exception.
- **DONE:** `div_valid`=1 for one cycle.
  - Next state is IDLE, or CALC/FIX if a start is accepted, giving back-to-back operation.
- **Flush:** `flush`=1 forces IDLE on the next edge from any state.
  - It also suppresses any pending `div_valid`.
  - Flush beats a simultaneous `start`.
- **Output stability:** `div_Rd`, `div_DI` and `div_rem` hold their last values outside DONE. Consumers gate them with `div_valid`.
- `busy` = (state==CALC || state==FIX).

## Timing
- **Reset:** `rst_n` low gives, immediately and asynchronously:
  - state IDLE;
  - `busy`=0 and `div_valid`=0;
  - `div_Rd`=0, `div_DI`=0, `div_rem`=0;
  - counter=0.
- Reset mid-operation discards the operation.
- **Nonzero divisor:** `start` is sampled at edge E0.
  - CALC during cycles 1–32.
  - FIX during cycle 33.
  - `div_valid` high during cycle 34 only.
  - `busy` high during cycles 1–33.
- **Zero divisor:** FIX during cycle 1, `div_valid` during cycle 2, `busy` high during cycle 1 only.
- **Back-to-back:** a start sampled in the DONE cycle begins the next CALC immediately. Throughput is one divide per 34 cycles.
- `div_valid` is registered and never combinationally dependent on inputs.

## Structure
- Shared package `div_pkg` holds:
  - state enum `div_state_t` {IDLE, CALC, FIX, DONE};
  - constants `DIV_WIDTH`=32, `DIV_ITER`=32, `DIV_ZERO_Q`='1.
- One sub-module, `div_paso`: a combinational single restoring step.
  - Inputs: {rem, quo, divisor}.
  - Outputs: next {rem, quo}.
  - Instantiated once in CALC.
- The FSM, counter, sign fixup and output registers live in `unidad_division`.

## Test plan
- Unsigned: `dividend`=100, `divisor`=7, `rd`=3, start at E0.
  - Required: `div_valid` only in cycle 34, `div_DI`=14, `div_rem`=2, `div_Rd`=3.
  - `busy` high exactly in cycles 1–33.
- Signed: −7 / 2 → `div_DI`=0xFFFFFFFD (−3), `div_rem`=0xFFFFFFFF (−1). Also 7 / −2 → −3 rem 1. Also 0x80000000 / 0xFFFFFFFF → 0x80000000 rem 0.
- Divide by zero: `dividend`=0x1234, `divisor`=0.
  - Required: `div_valid` in cycle 2, `div_DI`=0xFFFFFFFF, `div_rem`=0x1234.
- Busy rejection and back-to-back:
  - A second start in cycle 10 is ignored; exactly one `div_valid` is produced.
  - A start in the DONE cycle (rd=5, 50/5) gives `div_valid` 34 cycles later with `div_DI`=10, `div_Rd`=5.
- Flush and reset:
  - `flush` in cycle 20 → state IDLE, no `div_valid` ever for that op.
  - `rst_n` low mid-CALC → all outputs 0 immediately.
  - `flush`+`start` in the same cycle → no operation starts.
